// File: rtl/ts_multi_sensor_sequencer.sv
// APB-controlled scanner for N_CH temperature sensors: per-channel sample averaging,
// result registers, hi/lo threshold flags and a maskable interrupt.
`timescale 1ns/1ps
module ts_multi_sensor_sequencer #(
  parameter int N_CH        = 4,
  parameter int DATA_W      = 12,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 1023,
  parameter int ADDR_W      = 12
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   PSEL,
  input  logic [ADDR_W-1:0]      PADDR,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [31:0]            PWDATA,
  input  logic [3:0]             PSTRB,
  output logic [31:0]            PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  output logic [N_CH-1:0]        ts_start,
  input  logic [N_CH-1:0]        ts_rdy,
  input  logic [N_CH*DATA_W-1:0] ts_data,
  output logic                   irq
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SELECT, START, WAIT, ACCUM, STORE} state_t;

  state_t              state, state_n;
  logic                ctrl_en, ctrl_cont, first_scan;
  logic [N_CH-1:0]     ch_en;
  logic [24:0]         irq_stat, irq_mask, irq_stat_n, irq_mask_n, irq_set;
  logic [DATA_W-1:0]   thr_hi, thr_lo;
  logic [DATA_W-1:0]   result_avg [N_CH];
  logic [N_CH-1:0]     result_vld;
  logic [2:0]          cur_ch, sel_ch;
  logic                sel_found;
  logic [DATA_W-1:0]   sample_p0;
  logic [ACC_W-1:0]    acc_p1;
  logic [CNT_W-1:0]    samp_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                rdy_cur;
  logic [DATA_W-1:0]   data_cur, avg_val;
  logic                access, wr_ok, en_eff, go_req;
  logic                wr_ctrl, wr_chen, wr_stat, wr_mask, wr_hi, wr_lo;
  logic                mapped, ro;
  logic [31:0]         widx, rd_data;
  logic                unused_bits;

  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] a);
    return a[ACC_W-1:AVG_LOG2];
  endfunction

  assign unused_bits = ^{PADDR[1:0], PWDATA};

  assign access  = PSEL & PENABLE;
  assign wr_ok   = access & PWRITE & (PSTRB == 4'hF);
  assign widx    = 32'(PADDR[ADDR_W-1:2]);
  assign wr_ctrl = wr_ok && (widx == 32'd0);
  assign wr_chen = wr_ok && (widx == 32'd1);
  assign wr_stat = wr_ok && (widx == 32'd3);
  assign wr_mask = wr_ok && (widx == 32'd4);
  assign wr_hi   = wr_ok && (widx == 32'd5);
  assign wr_lo   = wr_ok && (widx == 32'd6);

  // EN/GO take effect in the cycle of the write so EN|GO in one access starts a scan
  assign en_eff  = wr_ctrl ? PWDATA[0] : ctrl_en;
  assign go_req  = wr_ctrl & PWDATA[2];

  assign irq_mask_n = wr_mask ? PWDATA[24:0] : irq_mask;
  assign irq_stat_n = (irq_stat & ~(wr_stat ? PWDATA[24:0] : 25'd0)) | irq_set;
  assign avg_val    = avg_trunc(acc_p1);
  assign PREADY     = 1'b1;

  always_comb begin
    rd_data = '0;
    mapped  = 1'b1;
    ro      = 1'b0;
    case (widx)
      32'd0: rd_data[1:0] = {ctrl_cont, ctrl_en};
      32'd1: rd_data[N_CH-1:0] = ch_en;
      32'd2: begin
        rd_data[0]          = (state != IDLE);
        rd_data[6:4]        = cur_ch;
        rd_data[8 +: CNT_W] = samp_cnt;
        ro                  = 1'b1;
      end
      32'd3: rd_data[24:0] = irq_stat;
      32'd4: rd_data[24:0] = irq_mask;
      32'd5: rd_data[DATA_W-1:0] = thr_hi;
      32'd6: rd_data[DATA_W-1:0] = thr_lo;
      default: begin
        mapped = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
          if (widx == 32'(8 + i)) begin
            rd_data[31]         = result_vld[i];
            rd_data[DATA_W-1:0] = result_avg[i];
            mapped              = 1'b1;
            ro                  = 1'b1;
          end
        end
      end
    endcase
  end

  assign PRDATA  = (access && !PWRITE) ? rd_data : 32'd0;
  assign PSLVERR = access & (~mapped | (PWRITE & ro));

  always_comb begin
    rdy_cur  = 1'b0;
    data_cur = '0;
    ts_start = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cur_ch == 3'(i)) begin
        rdy_cur     = ts_rdy[i];
        data_cur    = ts_data[i*DATA_W +: DATA_W];
        ts_start[i] = (state == START);
      end
    end
  end

  // lowest enabled channel above the current one; any enabled channel on a fresh pass
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_en[i] && (first_scan || (3'(i) > cur_ch))) begin
        sel_found = 1'b1;
        sel_ch    = 3'(i);
      end
    end
  end

  always_comb begin
    state_n = state;
    irq_set = '0;
    case (state)
      IDLE:   if (go_req && en_eff && (ch_en != '0)) state_n = SELECT;
      SELECT: begin
        if (sel_found)                     state_n = START;
        else if (ctrl_cont && !first_scan) state_n = SELECT;
        else                               state_n = IDLE;
      end
      START:  state_n = WAIT;
      WAIT: begin
        if (rdy_cur) state_n = ACCUM;
        else if (tmo_cnt == TMO_LAST) begin
          state_n     = SELECT;
          irq_set[24] = 1'b1;
        end
      end
      ACCUM:  state_n = (samp_cnt == LAST_SAMP) ? STORE : START;
      STORE: begin
        state_n = SELECT;
        irq_set = 25'd1 << cur_ch;
        if (avg_val > thr_hi) irq_set = irq_set | (25'd1 << (8 + cur_ch));
        if (avg_val < thr_lo) irq_set = irq_set | (25'd1 << (16 + cur_ch));
      end
      default: state_n = IDLE;
    endcase
    if (!en_eff) state_n = IDLE;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      ctrl_en    <= 1'b0;
      ctrl_cont  <= 1'b0;
      first_scan <= 1'b0;
      ch_en      <= '0;
      irq_stat   <= '0;
      irq_mask   <= '0;
      irq        <= 1'b0;
      thr_hi     <= '0;
      thr_lo     <= '0;
      result_vld <= '0;
      for (int i = 0; i < N_CH; i++) result_avg[i] <= '0;
      cur_ch     <= '0;
      sample_p0  <= '0;
      acc_p1     <= '0;
      samp_cnt   <= '0;
      tmo_cnt    <= '0;
    end else begin
      state    <= state_n;
      ctrl_en  <= en_eff;
      irq_mask <= irq_mask_n;
      irq_stat <= irq_stat_n;
      irq      <= |(irq_stat_n & irq_mask_n);
      if (wr_ctrl) ctrl_cont <= PWDATA[1];
      if (wr_chen) ch_en     <= PWDATA[N_CH-1:0];
      if (wr_hi)   thr_hi    <= PWDATA[DATA_W-1:0];
      if (wr_lo)   thr_lo    <= PWDATA[DATA_W-1:0];
      case (state)
        IDLE: begin
          acc_p1   <= '0;
          samp_cnt <= '0;
          if (state_n == SELECT) first_scan <= 1'b1;
        end
        SELECT: begin
          acc_p1   <= '0;
          samp_cnt <= '0;
          if (sel_found) begin
            cur_ch     <= sel_ch;
            first_scan <= 1'b0;
          end else begin
            first_scan <= 1'b1;
          end
        end
        START: tmo_cnt <= '0;
        // stage 0: capture the sample of the active channel
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (rdy_cur) sample_p0 <= data_cur;
        end
        // stage 1: accumulate
        ACCUM: begin
          acc_p1   <= acc_p1 + ACC_W'(sample_p0);
          samp_cnt <= samp_cnt + 1'b1;
        end
        // stage 2: average and commit the result
        STORE: begin
          for (int i = 0; i < N_CH; i++) begin
            if (cur_ch == 3'(i)) begin
              result_avg[i] <= avg_val;
              result_vld[i] <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
